// File: rtl/npc_sequencer.sv
// Next-PC sequencer for the IF stage: redirect selection, stall buffering, delay-slot flag.
// Optional fetch-address fault check built when INSTR_ADDR_CHECK_EN is defined.
module npc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_PC   = 32'h0000_4180,
   parameter logic [31:0] TEXT_LO  = 32'h0000_3000,
   parameter logic [31:0] TEXT_HI  = 32'h0000_6ffc
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IF_PC,
   input  logic        stall,
   input  logic        D_br_valid,
   input  logic        D_br_taken,
   input  logic [31:0] D_br_target,
   input  logic        req,
   input  logic        eret,
   input  logic [31:0] EPC,
`ifdef INSTR_ADDR_CHECK_EN
   output logic        IF_excAdEL,
`endif
   output logic [31:0] NPC,
   output logic        enablePC,
   output logic        IF_BD
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_PEND = 1'b1
   } state_t;

   state_t      r_state;
   logic [31:0] r_pend_target;
   logic        r_bd_hold;

   logic        w_flush;
   logic        w_taken;
   logic        w_pend_valid;
   logic [31:0] w_seq_pc;
   logic [31:0] w_npc;

   assign w_flush      = req | eret;
   assign w_taken      = D_br_valid & D_br_taken;
   assign w_pend_valid = (r_state == S_PEND);
   assign w_seq_pc     = IF_PC + 32'd4;

   always_comb begin
      w_npc = w_seq_pc;
      priority case (1'b1)
         reset:        w_npc = RESET_PC;
         req:          w_npc = EXC_PC;
         eret:         w_npc = EPC;
         stall:        w_npc = IF_PC;
         w_pend_valid: w_npc = r_pend_target;
         w_taken:      w_npc = D_br_target;
         default:      w_npc = w_seq_pc;
      endcase
   end

   assign NPC      = w_npc;
   assign enablePC = reset | w_flush | ~stall;
   assign IF_BD    = (D_br_valid | r_bd_hold)
                   & ~w_flush & ~reset;

   // Exceptions and eret discard any buffered redirect.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_pend_target <= '0;
         r_bd_hold     <= 1'b0;
      end else if (w_flush || !stall) begin
         r_state   <= S_IDLE;
         r_bd_hold <= 1'b0;
      end else begin
         if (D_br_valid)
            r_bd_hold <= 1'b1;
         unique case (r_state)
            S_IDLE: begin
               if (w_taken) begin
                  r_state       <= S_PEND;
                  r_pend_target <= D_br_target;
               end
            end
            S_PEND: begin
               if (w_taken)
                  r_pend_target <= D_br_target;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef INSTR_ADDR_CHECK_EN
   logic w_misalign;
   logic w_out_range;

   assign w_misalign  = (IF_PC[1:0] != 2'b00);
   assign w_out_range = (IF_PC < TEXT_LO)
                      | (IF_PC > TEXT_HI);
   assign IF_excAdEL  = ~reset
                      & (w_misalign | w_out_range);
`endif

endmodule

// File: tb/tb_npc_sequencer.sv
// Randomized closed-loop bench for npc_sequencer against a rule-level model.
// The model plays the IF PC register, loading NPC whenever enablePC is expected.
module tb_npc_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] EXC    = 32'h0000_4180;
   localparam logic [31:0] LO     = 32'h0000_3000;
   localparam logic [31:0] HI     = 32'h0000_6ffc;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] IF_PC;
   logic        stall;
   logic        D_br_valid;
   logic        D_br_taken;
   logic [31:0] D_br_target;
   logic        req;
   logic        eret;
   logic [31:0] EPC;
   logic [31:0] NPC;
   logic        enablePC;
   logic        IF_BD;
`ifdef INSTR_ADDR_CHECK_EN
   logic        IF_excAdEL;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // model state
   bit          m_pend;
   logic [31:0] m_tgt;
   bit          m_hold;

   always #5 clk = ~clk;

   npc_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .IF_PC       (IF_PC),
      .stall       (stall),
      .D_br_valid  (D_br_valid),
      .D_br_taken  (D_br_taken),
      .D_br_target (D_br_target),
      .req         (req),
      .eret        (eret),
      .EPC         (EPC),
`ifdef INSTR_ADDR_CHECK_EN
      .IF_excAdEL  (IF_excAdEL),
`endif
      .NPC         (NPC),
      .enablePC    (enablePC),
      .IF_BD       (IF_BD)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_npc();
      if (reset)                   return RST_PC;
      if (req)                     return EXC;
      if (eret)                    return EPC;
      if (stall)                   return IF_PC;
      if (m_pend)                  return m_tgt;
      if (D_br_valid & D_br_taken) return D_br_target;
      return IF_PC + 32'd4;
   endfunction

   function automatic logic exp_en();
      return reset | req | eret | ~stall;
   endfunction

   function automatic logic exp_bd();
      if (reset || req || eret) return 1'b0;
      return D_br_valid | m_hold;
   endfunction

   function automatic logic exp_adel();
      if (reset) return 1'b0;
      return (IF_PC[1:0] != 2'b00) || (IF_PC < LO) || (IF_PC > HI);
   endfunction

   task automatic set_in(input logic r, input logic s,
                         input logic bv, input logic bt,
                         input logic [31:0] tg,
                         input logic rq, input logic er,
                         input logic [31:0] ep);
      reset = r; stall = s;
      D_br_valid = bv; D_br_taken = bt;
      D_br_target = tg;
      req = rq; eret = er; EPC = ep;
   endtask

   // check outputs, clock once, advance model and IF PC
   task automatic cycle(input string tag);
      logic [31:0] npc_e;
      logic        en_e;
      #1;
      npc_e = exp_npc();
      en_e  = exp_en();
      chk({tag, ".npc"}, NPC, npc_e);
      chk({tag, ".en"}, {31'd0, enablePC}, {31'd0, en_e});
      chk({tag, ".bd"}, {31'd0, IF_BD}, {31'd0, exp_bd()});
`ifdef INSTR_ADDR_CHECK_EN
      chk({tag, ".adel"}, {31'd0, IF_excAdEL},
          {31'd0, exp_adel()});
`endif
      @(posedge clk);
      if (reset) begin
         m_pend = 0; m_tgt = '0; m_hold = 0;
      end else if (req || eret || !stall) begin
         m_pend = 0; m_hold = 0;
      end else begin
         if (D_br_valid && D_br_taken) begin
            m_pend = 1; m_tgt = D_br_target;
         end
         if (D_br_valid) m_hold = 1;
      end
      #1;
      if (en_e) IF_PC = npc_e;
   endtask

   initial begin
      m_pend = 0; m_tgt = '0; m_hold = 0;
      IF_PC = '0;
      set_in(1, 0, 0, 0, '0, 0, 0, '0);
      @(negedge clk);

      // reset
      #1;
      chk("rst_npc", NPC, RST_PC);
      chk("rst_en", {31'd0, enablePC}, 32'd1);
      chk("rst_bd", {31'd0, IF_BD}, 32'd0);
      cycle("rst");
      set_in(0, 0, 0, 0, '0, 0, 0, '0);
      #1 chk("seq_npc", NPC, 32'h3004);
      cycle("seq");

      // taken, no stall
      IF_PC = 32'h3008;
      set_in(0, 0, 1, 1, 32'h3040, 0, 0, '0);
      #1 chk("tk_npc", NPC, 32'h3040);
      chk("tk_bd", {31'd0, IF_BD}, 32'd1);
      cycle("tk");
      set_in(0, 0, 0, 0, '0, 0, 0, '0);
      #1 chk("tk_bd2", {31'd0, IF_BD}, 32'd0);
      cycle("tk2");

      // taken during 3-cycle stall
      IF_PC = 32'h3008;
      set_in(0, 1, 1, 1, 32'h3040, 0, 0, '0);
      for (int i = 0; i < 3; i++) begin
         #1 chk("st_npc", NPC, 32'h3008);
         chk("st_en", {31'd0, enablePC}, 32'd0);
         chk("st_bd", {31'd0, IF_BD}, 32'd1);
         cycle("st");
         set_in(0, 1, 0, 0, '0, 0, 0, '0);
      end
      set_in(0, 0, 0, 0, '0, 0, 0, '0);
      #1 chk("sd_npc", NPC, 32'h3040);
      chk("sd_en", {31'd0, enablePC}, 32'd1);
      cycle("sd");
      #1 chk("sd_after", NPC, 32'h3044);
      cycle("sd2");

      // req while stalled with pending target
      IF_PC = 32'h3008;
      set_in(0, 1, 1, 1, 32'h3040, 0, 0, '0);
      cycle("pq0");
      set_in(0, 1, 0, 0, '0, 1, 0, '0);
      #1 chk("rq_npc", NPC, EXC);
      chk("rq_en", {31'd0, enablePC}, 32'd1);
      cycle("rq");
      set_in(0, 0, 0, 0, '0, 0, 0, '0);
      #1 chk("rq_after", NPC, 32'h4184);
      cycle("rq2");

      // req+eret, then eret alone
      set_in(0, 0, 0, 0, '0, 1, 1, 32'h3100);
      #1 chk("rqer_npc", NPC, EXC);
      cycle("rqer");
      set_in(0, 0, 1, 0, '0, 0, 1, 32'h3100);
      #1 chk("er_npc", NPC, 32'h3100);
      chk("er_bd", {31'd0, IF_BD}, 32'd0);
      cycle("er");

      // reset mid-PEND
      set_in(0, 1, 1, 1, 32'h3200, 0, 0, '0);
      cycle("rp0");
      set_in(1, 1, 0, 0, '0, 0, 0, '0);
      cycle("rp1");
      set_in(0, 0, 0, 0, '0, 0, 0, '0);
      #1 chk("rp_npc", NPC, 32'h3004);
      cycle("rp2");

`ifdef INSTR_ADDR_CHECK_EN
      set_in(0, 1, 0, 0, '0, 0, 0, '0);
      IF_PC = 32'h3002;
      #1 chk("adel_mis", {31'd0, IF_excAdEL}, 32'd1);
      IF_PC = 32'h7000;
      #1 chk("adel_hi", {31'd0, IF_excAdEL}, 32'd1);
      IF_PC = 32'h6ffc;
      #1 chk("adel_ok", {31'd0, IF_excAdEL}, 32'd0);
      cycle("adel");
      set_in(0, 0, 0, 0, '0, 0, 0, '0);
      cycle("adel2");
`endif

      // randomized closed loop
      for (int i = 0; i < 400; i++) begin
         logic [31:0] t;
         logic [31:0] e;
         t = LO + ($urandom_range(0, 4095) << 2);
         e = LO + ($urandom_range(0, 4095) << 2);
         set_in($urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 35,
                $urandom_range(0, 99) < 25,
                $urandom_range(0, 1) == 1,
                t,
                $urandom_range(0, 99) < 5,
                $urandom_range(0, 99) < 5,
                e);
         if ($urandom_range(0, 99) < 3)
            IF_PC = $urandom;
         cycle("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
